// File: rtl/riscv8_pkg.sv
// riscv8_pkg: shared types and widths for the 8-bit RISC-V pipeline stages.
package riscv8_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  // MEM/WB pipeline register payload
  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_register;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
  } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, fetch feedback and MEM/WB outputs of the memory stage.
// Forwarding signals exist only when MEM_FWD_EN is defined.
interface mem_stage_if
  import riscv8_pkg::*;
#(
  parameter int unsigned PC_SIZE = 10
);
  logic [PC_SIZE-1:0]    PC_jump_in;
  logic                  zero_in;
  logic [DATA_W-1:0]     ALU_result_in;
  logic [DATA_W-1:0]     write_data_in;
  logic                  branch_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic                  mem_to_reg_in;
  logic                  reg_write_in;
  logic [REG_ADDR_W-1:0] write_register_in;

  logic                  PC_src;
  logic [PC_SIZE-1:0]    PC_branch;
  logic                  stall;
  logic [DATA_W-1:0]     read_data_out;
  logic [DATA_W-1:0]     ALU_result_out;
  logic                  mem_to_reg_out;
  logic                  reg_write_out;
  logic [REG_ADDR_W-1:0] write_register_out;
`ifdef MEM_FWD_EN
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_register;
  logic [DATA_W-1:0]     fwd_data;
`endif

  modport master (
    output PC_jump_in, zero_in, ALU_result_in, write_data_in, branch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, write_register_in,
`ifdef MEM_FWD_EN
    input  fwd_valid, fwd_register, fwd_data,
`endif
    input  PC_src, PC_branch, stall, read_data_out, ALU_result_out,
           mem_to_reg_out, reg_write_out, write_register_out
  );

  modport slave (
    input  PC_jump_in, zero_in, ALU_result_in, write_data_in, branch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, write_register_in,
`ifdef MEM_FWD_EN
    output fwd_valid, fwd_register, fwd_data,
`endif
    output PC_src, PC_branch, stall, read_data_out, ALU_result_out,
           mem_to_reg_out, reg_write_out, write_register_out
  );

endinterface

// File: rtl/data_memory.sv
// data_memory: byte-wide data array, synchronous write, combinational read, no reset.
module data_memory #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Store port; contents survive reset
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read returns the pre-write byte in a same-cycle read/write
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Multi-cycle loads/stores stall upstream and
// push bubbles into MEM/WB; taken branches are resolved here.
// Optional combinational forwarding outputs are built when MEM_FWD_EN is defined.
module mem_stage
  import riscv8_pkg::*;
#(
  parameter int unsigned PC_SIZE     = 10,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  mem_stage_if.slave bus
);

  localparam int unsigned CNT_W       = $clog2(MEM_LATENCY) + 1;
  localparam bit          MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam int unsigned CNT_LOAD    = MULTI_CYCLE ? (MEM_LATENCY - 2) : 32'd0;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  memwb_t            memwb_q, memwb_d;

  logic              access_c;
  logic              stall_c;
  logic              complete_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [PC_SIZE-1:0] pc_branch_c;

  assign access_c   = bus.mem_read_in | bus.mem_write_in;
  assign mem_addr_c = bus.ALU_result_in[ADDR_W-1:0];
  // A reset arriving mid-access drops it without touching the array
  assign mem_we_c   = complete_c & bus.mem_write_in & ~reset;

  data_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dmem (
    .clock   (clock),
    .we_i    (mem_we_c),
    .addr_i  (mem_addr_c),
    .wdata_i (bus.write_data_in),
    .rdata_o (mem_rdata_c)
  );

  // Access sequencing: next state, latency counter, stall and completion strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (access_c) begin
          if (MULTI_CYCLE) begin
            state_d = MEM_BUSY;
            cnt_d   = CNT_W'(CNT_LOAD);
            stall_c = 1'b1;
          end else begin
            complete_c = 1'b1;
          end
        end
      end
      MEM_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          stall_c = 1'b1;
        end else begin
          complete_c = 1'b1;
          state_d    = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // MEM/WB next value: bubble while stalled, otherwise capture the inputs
  always_comb begin
    memwb_d = memwb_q;
    if (stall_c) begin
      memwb_d.reg_write  = 1'b0;
      memwb_d.mem_to_reg = 1'b0;
    end else begin
      memwb_d.reg_write      = bus.reg_write_in;
      memwb_d.mem_to_reg     = bus.mem_to_reg_in;
      memwb_d.write_register = bus.write_register_in;
      memwb_d.alu_result     = bus.ALU_result_in;
      if (complete_c && bus.mem_read_in) begin
        memwb_d.read_data = mem_rdata_c;
      end
    end
  end

  // State, counter and MEM/WB registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      memwb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      memwb_q <= memwb_d;
    end
  end

  assign pc_branch_c            = bus.PC_jump_in;
  assign bus.PC_branch          = pc_branch_c;
  assign bus.PC_src             = bus.branch_in & bus.zero_in & ~stall_c;
  assign bus.stall              = stall_c;
  assign bus.read_data_out      = memwb_q.read_data;
  assign bus.ALU_result_out     = memwb_q.alu_result;
  assign bus.mem_to_reg_out     = memwb_q.mem_to_reg;
  assign bus.reg_write_out      = memwb_q.reg_write;
  assign bus.write_register_out = memwb_q.write_register;

`ifdef MEM_FWD_EN
  // ALU results are forwardable straight from EX/MEM; loads are not
  assign bus.fwd_valid    = bus.reg_write_in & ~bus.mem_read_in & ~stall_c;
  assign bus.fwd_register = bus.write_register_in;
  assign bus.fwd_data     = bus.ALU_result_in;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 8-bit RISC-V pipeline, consuming the EX/MEM register outputs of the execute stage. It performs data-memory loads and stores against an internal byte-wide memory, resolves taken branches, and drives the MEM/WB pipeline register. Memory accesses take a configurable number of cycles; while an access is outstanding, the block stalls upstream with `stall` and inserts bubbles into MEM/WB.

## Interface
- `PC_SIZE`, 10, width of the program counter and branch target.
- `ADDR_W`, 8, data-memory address width; depth is 2^ADDR_W bytes.
- `MEM_LATENCY`, 1, cycles per load/store, ≥1.

- `clock` in 1: single clock for the block.
- `reset` in 1: asynchronous, active-high.
- `PC_jump_in` in PC_SIZE: branch target from EX/MEM.
- `zero_in` in 1: ALU zero flag.
- `ALU_result_in` in 8: ALU result; the address is `[ADDR_W-1:0]`.
- `write_data_in` in 8: store data.
- `branch_in`, `mem_read_in`, `mem_write_in`, `mem_to_reg_in`, `reg_write_in` in 1 each: control bits.
- `write_register_in` in 5: destination register.
- `PC_src` out 1: take-branch select to fetch.
- `PC_branch` out PC_SIZE: branch target to fetch.
- `stall` out 1: hold EX/MEM and all earlier stages.
- `read_data_out` out 8: MEM/WB load data.
- `ALU_result_out` out 8: MEM/WB ALU result.
- `mem_to_reg_out`, `reg_write_out` out 1: MEM/WB control bits.
- `write_register_out` out 5: MEM/WB destination register.

## Operation
- An access is `mem_read_in | mem_write_in`. If both are set, the write is performed and `read_data_out` captures the pre-write byte.
- FSM states are IDLE and BUSY, with a down-counter of width $clog2(MEM_LATENCY)+1.
- **IDLE, no access:** MEM/WB captures the inputs every cycle.
- **IDLE, access, MEM_LATENCY=1:** the access completes at the next edge.
  - Store: the array is written.
  - Load: `read_data_out` is loaded with `mem[addr]`.
  - MEM/WB captures the inputs.
- **IDLE, access, MEM_LATENCY>1:** go to BUSY, load the counter with MEM_LATENCY-2, and write a bubble to MEM/WB (`reg_write_out=0`, `mem_to_reg_out=0`).
- **BUSY, counter≠0:** decrement the counter and write a bubble.
- **BUSY, counter=0:** complete the access as in the MEM_LATENCY=1 case, capture MEM/WB, and return to IDLE.
- `stall` = (IDLE & access & MEM_LATENCY>1) | (BUSY & counter≠0). It is combinational.
- Upstream holds all inputs stable while `stall`=1. The block samples the inputs only on the completing edge.
- `PC_src` = `branch_in & zero_in & ~stall` and is combinational. `PC_branch` = `PC_jump_in`.
- The address wraps modulo 2^ADDR_W; `ALU_result_in` bits above ADDR_W are ignored.

## Timing
- **Reset (asynchronous):**
  - FSM goes to IDLE; counter = 0; all MEM/WB outputs = 0.
  - `stall` = 0, unless an access is present on the inputs.
  - Memory contents are not cleared.
- **Reset mid-BUSY:** the pending access is dropped, with no array write. It re-executes when reset releases and the inputs are still presented.
- **Load-to-WB latency:** MEM_LATENCY edges from the first cycle the access is presented.
- **Stall duration:** `stall` is high for exactly MEM_LATENCY-1 cycles per access.
- **Back-to-back accesses:** the second access enters from IDLE on the cycle after completion. There is no idle gap beyond the cycle in which `stall`=0.
- **Branch with an access:** `PC_src` is held low until the completing cycle and asserts in that cycle.

## Configuration
- `MEM_FWD_EN` defined:
  - Adds outputs `fwd_valid` (1), `fwd_register` (5) and `fwd_data` (8), all combinational.
  - `fwd_valid` = `reg_write_in & ~mem_read_in & ~stall`.
  - `fwd_register` = `write_register_in`; `fwd_data` = `ALU_result_in`.
- `MEM_FWD_EN` undefined: these ports and the logic are absent.

## Structure
- Package `riscv8_pkg` holds:
  - `mem_state_t` enum {MEM_IDLE, MEM_BUSY};
  - `REG_ADDR_W`=5;
  - `DATA_W`=8.
- Sub-module `data_memory`: a 2^ADDR_W × 8 array with synchronous write, combinational read and no reset. The FSM, counter and MEM/WB register stay in `mem_stage`.

## Test plan
- **Store then load, MEM_LATENCY=1:**
  - Store 0xA5 to address 0x10; the next cycle, load 0x10 with `mem_to_reg_in`=1 and `write_register_in`=7.
  - One edge later: `read_data_out`=0xA5, `write_register_out`=7, `reg_write_out`=1.
  - `stall` never asserts.
- **MEM_LATENCY=3 load:**
  - `stall` is high for 2 cycles and MEM/WB holds bubbles for 2 cycles.
  - The loaded data appears on the 3rd edge, after which `stall` = 0.
- **Branch:**
  - Inputs: `branch_in`=1, `zero_in`=1, `PC_jump_in`=0x2C.
  - Same cycle: `PC_src`=1, `PC_branch`=0x2C.
  - With `zero_in`=0: `PC_src`=0.
- **Reset in BUSY (MEM_LATENCY=4):**
  - Assert `reset` during the 2nd stall cycle of a store of 0x33 to address 0x05.
  - Outputs clear immediately. After release with the inputs idle, address 0x05 holds its old value.
- **Address wrap and read/write conflict:**
  - Store 0x77 with `ALU_result_in`=0xFF and ADDR_W=4, then load 0x0F → 0x77.
  - Simultaneous read and write → the array is updated and `read_data_out` shows the old byte.
- **MEM_FWD_EN:**
  - Inputs: ALU instruction, `reg_write_in`=1, `write_register_in`=3, `ALU_result_in`=0x42.
  - Response: `fwd_valid`=1, `fwd_register`=3, `fwd_data`=0x42.
  - With `mem_read_in`=1: `fwd_valid`=0.
